// File: rtl/interp_pkg.sv
// Shared types for the wavetable linear interpolator.
// Mode encoding and product width helper.
package interp_pkg;

  typedef enum logic [1:0] {
    LIN_TRUNC = 2'b00,
    LIN_ROUND = 2'b01,
    NEAREST   = 2'b10,
    HOLD      = 2'b11
  } interp_mode_t;

  // signed (WIDTH+1) difference times unsigned (FRAC_BITS+1) fraction
  function automatic int prod_width(
    input int width,
    input int frac_bits
  );
    return width + 1 + frac_bits + 1;
  endfunction

endpackage

// File: rtl/interp_stage.sv
// Generic pipeline register: valid bit plus payload,
// advanced by a shared enable, cleared asynchronously.
module interp_stage #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_data  <= in_data;
    end
  end

endmodule

// File: rtl/lin_interp_pipe.sv
// Three-stage linear interpolator with valid/ready flow
// control; one tuple per cycle, three cycles of latency.
module lin_interp_pipe
  import interp_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int FRAC_BITS = 6,
  parameter int CH_BITS   = 5
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [WIDTH-1:0]     SAMPLE_1,
  input  logic [WIDTH-1:0]     SAMPLE_2,
  input  logic [FRAC_BITS-1:0] FRAC,
  input  interp_mode_t         MODE,
  input  logic [CH_BITS-1:0]   CH_IN,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [WIDTH-1:0]     SAMPLE_OUT,
  output logic [CH_BITS-1:0]   CH_OUT
);

  localparam int PW = prod_width(WIDTH, FRAC_BITS);

  localparam logic [FRAC_BITS-1:0] HALF_F =
    {1'b1, {(FRAC_BITS-1){1'b0}}};

  localparam logic [PW-1:0] RND_K =
    PW'(2 ** (FRAC_BITS - 1));

  typedef struct packed {
    logic [WIDTH-1:0]     s1;
    logic [WIDTH:0]       d;
    logic [FRAC_BITS-1:0] frac;
    interp_mode_t         mode;
    logic [CH_BITS-1:0]   ch;
  } st1_t;

  typedef struct packed {
    logic [WIDTH-1:0]   s1;
    logic [PW-1:0]      term;
    logic               rnd;
    logic [CH_BITS-1:0] ch;
  } st2_t;

  typedef struct packed {
    logic [WIDTH-1:0]   sample;
    logic [CH_BITS-1:0] ch;
  } st3_t;

  logic en;
  logic v1;
  logic v2;
  st1_t st1_d;
  st1_t st1_q;
  st2_t st2_d;
  st2_t st2_q;
  st3_t st3_d;
  st3_t st3_q;

  assign en       = !OUT_VALID || OUT_READY;
  assign IN_READY = en;

  // difference is one bit wider so full-scale swings never wrap
  logic signed [WIDTH:0] d_in;

  assign d_in =
    $signed({SAMPLE_2[WIDTH-1], SAMPLE_2}) -
    $signed({SAMPLE_1[WIDTH-1], SAMPLE_1});

  always_comb begin
    st1_d      = '0;
    st1_d.s1   = SAMPLE_1;
    st1_d.d    = d_in;
    st1_d.frac = FRAC;
    st1_d.mode = MODE;
    st1_d.ch   = CH_IN;
  end

  interp_stage #(.DW($bits(st1_t))) u_s1 (
    .clk       (Clk),
    .rst       (Reset),
    .en        (en),
    .in_valid  (IN_VALID),
    .in_data   (st1_d),
    .out_valid (v1),
    .out_data  (st1_q)
  );

  logic signed [PW-1:0] d_ext;
  logic signed [PW-1:0] f_ext;
  logic signed [PW-1:0] prod;

  assign d_ext = PW'($signed(st1_q.d));
  assign f_ext = PW'($signed({1'b0, st1_q.frac}));
  assign prod  = d_ext * f_ext;

  // nearest picks S2 by feeding the whole difference forward
  always_comb begin
    st2_d      = '0;
    st2_d.s1   = st1_q.s1;
    st2_d.ch   = st1_q.ch;
    st2_d.term = '0;
    st2_d.rnd  = 1'b0;
    unique case (1'b1)
      (st1_q.mode == LIN_TRUNC): begin
        st2_d.term = prod;
      end
      (st1_q.mode == LIN_ROUND): begin
        st2_d.term = prod;
        st2_d.rnd  = 1'b1;
      end
      (st1_q.mode == NEAREST): begin
        if (st1_q.frac >= HALF_F)
          st2_d.term = d_ext <<< FRAC_BITS;
      end
      (st1_q.mode == HOLD): begin
        st2_d.term = '0;
      end
      default: begin
        st2_d.term = '0;
      end
    endcase
  end

  interp_stage #(.DW($bits(st2_t))) u_s2 (
    .clk       (Clk),
    .rst       (Reset),
    .en        (en),
    .in_valid  (v1),
    .in_data   (st2_d),
    .out_valid (v2),
    .out_data  (st2_q)
  );

  logic signed [PW-1:0] acc;

  assign acc =
    st2_q.term + (st2_q.rnd ? RND_K : '0);

  always_comb begin
    st3_d        = '0;
    st3_d.sample =
      st2_q.s1 + WIDTH'(acc >>> FRAC_BITS);
    st3_d.ch     = st2_q.ch;
  end

  interp_stage #(.DW($bits(st3_t))) u_s3 (
    .clk       (Clk),
    .rst       (Reset),
    .en        (en),
    .in_valid  (v2),
    .in_data   (st3_d),
    .out_valid (OUT_VALID),
    .out_data  (st3_q)
  );

  assign SAMPLE_OUT = st3_q.sample;
  assign CH_OUT     = st3_q.ch;

endmodule

// File: tb/tb_lin_interp_pipe.sv
// Directed and randomised checks for lin_interp_pipe.
// WIDTH=16, FRAC_BITS=6, CH_BITS=5.
module tb_lin_interp_pipe;
  import interp_pkg::*;

  logic         Clk = 1'b0;
  logic         Reset = 1'b0;
  logic         IN_VALID = 1'b0;
  logic         IN_READY;
  logic [15:0]  SAMPLE_1 = '0;
  logic [15:0]  SAMPLE_2 = '0;
  logic [5:0]   FRAC = '0;
  interp_mode_t MODE = LIN_TRUNC;
  logic [4:0]   CH_IN = '0;
  logic         OUT_VALID;
  logic         OUT_READY = 1'b1;
  logic [15:0]  SAMPLE_OUT;
  logic [4:0]   CH_OUT;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [15:0] exp;
    logic [4:0]  ch;
    int          lo;
    int          hi;
  } exp_t;

  exp_t q[$];

  lin_interp_pipe #(
    .WIDTH(16), .FRAC_BITS(6), .CH_BITS(5)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .SAMPLE_1   (SAMPLE_1),
    .SAMPLE_2   (SAMPLE_2),
    .FRAC       (FRAC),
    .MODE       (MODE),
    .CH_IN      (CH_IN),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .SAMPLE_OUT (SAMPLE_OUT),
    .CH_OUT     (CH_OUT)
  );

  always #5 Clk = ~Clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    repeat (n) @(negedge Clk);
  endtask

  // single tuple into an empty pipe; checks 3-cycle latency
  task automatic run_one(
    input string        tag,
    input logic [15:0]  s1,
    input logic [15:0]  s2,
    input logic [5:0]   f,
    input interp_mode_t m,
    input logic [4:0]   ch,
    input logic [15:0]  exp
  );
    SAMPLE_1  = s1;
    SAMPLE_2  = s2;
    FRAC      = f;
    MODE      = m;
    CH_IN     = ch;
    IN_VALID  = 1'b1;
    OUT_READY = 1'b1;
    #1;
    chk({tag, "_rdy"}, 32'(IN_READY), 1);
    @(posedge Clk);
    #1 IN_VALID = 1'b0;
    @(negedge Clk);
    chk({tag, "_lat1"}, 32'(OUT_VALID), 0);
    @(negedge Clk);
    chk({tag, "_lat2"}, 32'(OUT_VALID), 0);
    @(negedge Clk);
    chk({tag, "_lat3"}, 32'(OUT_VALID), 1);
    chk(tag, 32'(SAMPLE_OUT), 32'(exp));
    chk({tag, "_ch"}, 32'(CH_OUT), 32'(ch));
  endtask

  function automatic int fdiv64(input int p);
    if (p >= 0) return p / 64;
    return -((-p + 63) / 64);
  endfunction

  function automatic logic [15:0] ref_model(
    input logic [15:0]  s1,
    input logic [15:0]  s2,
    input logic [5:0]   f,
    input interp_mode_t m
  );
    int a;
    int b;
    int p;
    a = int'($signed(s1));
    b = int'($signed(s2));
    p = (b - a) * int'(f);
    case (m)
      LIN_TRUNC: return 16'(a + fdiv64(p));
      LIN_ROUND: return 16'(a + fdiv64(p + 32));
      NEAREST:   return (f >= 6'd32) ? s2 : s1;
      default:   return s1;
    endcase
  endfunction

  initial begin
    int   sent;
    int   rcv;
    logic acc;
    exp_t e;
    int   r;

    // reset state
    #2 Reset = 1'b1;
    @(negedge Clk);
    chk("rst_ovalid", 32'(OUT_VALID), 0);
    chk("rst_sample", 32'(SAMPLE_OUT), 0);
    chk("rst_ch", 32'(CH_OUT), 0);
    chk("rst_ready", 32'(IN_READY), 1);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    chk("post_rst_ready", 32'(IN_READY), 1);

    run_one("trunc_mid", 16'h0000, 16'h0100,
            6'd32, LIN_TRUNC, 5'd3, 16'h0080);
    run_one("fs_trunc", 16'h7FFF, 16'h8000,
            6'd32, LIN_TRUNC, 5'd1, 16'hFFFF);
    run_one("fs_round", 16'h7FFF, 16'h8000,
            6'd32, LIN_ROUND, 5'd2, 16'h0000);
    run_one("near_31", 16'h1000, 16'h2000,
            6'd31, NEAREST, 5'd4, 16'h1000);
    run_one("near_32", 16'h1000, 16'h2000,
            6'd32, NEAREST, 5'd5, 16'h2000);
    run_one("near_63", 16'h1000, 16'h2000,
            6'd63, NEAREST, 5'd6, 16'h2000);
    run_one("hold_63", 16'h1000, 16'h2000,
            6'd63, HOLD, 5'd7, 16'h1000);
    run_one("round_f0", 16'h7FFF, 16'h8000,
            6'd0, LIN_ROUND, 5'd8, 16'h7FFF);
    run_one("neg_trunc", 16'h0010, 16'h0000,
            6'd1, LIN_TRUNC, 5'd9, 16'h000F);
    run_one("neg_round", 16'h0010, 16'h0000,
            6'd1, LIN_ROUND, 5'd10, 16'h0010);
    run_one("trunc_f63", 16'hFF00, 16'h0100,
            6'd63, LIN_TRUNC, 5'd31, 16'h00F8);

    // back-to-back stream with a three-cycle output stall
    idle(4);
    sent = 0;
    rcv  = 0;
    for (int c = 0; c < 30 && rcv < 8; c++) begin
      OUT_READY = !(c >= 4 && c <= 6);
      IN_VALID  = (sent < 8);
      SAMPLE_1  = 16'(sent * 16);
      SAMPLE_2  = 16'(sent * 16 + 64);
      FRAC      = 6'd16;
      MODE      = LIN_TRUNC;
      CH_IN     = 5'(sent);
      #1;
      if (c >= 4 && c <= 6)
        chk("stall_ready", 32'(IN_READY), 0);
      if (OUT_VALID) begin
        chk("stream_data", 32'(SAMPLE_OUT),
            32'(rcv * 16 + 16));
        chk("stream_ch", 32'(CH_OUT), 32'(rcv % 32));
        if (OUT_READY) rcv++;
      end
      acc = IN_VALID && IN_READY;
      @(posedge Clk);
      if (acc) sent++;
      @(negedge Clk);
    end
    chk("stream_count", 32'(rcv), 8);
    chk("stream_sent", 32'(sent), 8);
    idle(1);
    repeat (3) begin
      chk("stream_no_dup", 32'(OUT_VALID), 0);
      @(negedge Clk);
    end

    // reset with three tuples in flight
    for (int k = 0; k < 3; k++) begin
      SAMPLE_1 = 16'(16'h1234 + k);
      SAMPLE_2 = 16'h0000;
      FRAC     = 6'd5;
      MODE     = HOLD;
      CH_IN    = 5'(7 + k);
      IN_VALID = 1'b1;
      @(negedge Clk);
    end
    IN_VALID = 1'b0;
    chk("inflight_valid", 32'(OUT_VALID), 1);
    chk("inflight_data", 32'(SAMPLE_OUT), 32'h1234);
    #2 Reset = 1'b1;
    #1;
    chk("arst_ovalid", 32'(OUT_VALID), 0);
    chk("arst_sample", 32'(SAMPLE_OUT), 0);
    chk("arst_ch", 32'(CH_OUT), 0);
    chk("arst_ready", 32'(IN_READY), 1);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (4) begin
      chk("no_stale", 32'(OUT_VALID), 0);
      @(negedge Clk);
    end
    run_one("after_rst", 16'h0100, 16'h0200,
            6'd48, LIN_ROUND, 5'd12, 16'h01C0);

    // random traffic against the reference model
    idle(4);
    sent = 0;
    rcv  = 0;
    for (int c = 0; c < 40000
         && (sent < 10000 || q.size() != 0); c++) begin
      OUT_READY = ($urandom_range(0, 3) != 0);
      IN_VALID  = (sent < 10000)
                  && ($urandom_range(0, 4) != 0);
      SAMPLE_1  = 16'($urandom);
      SAMPLE_2  = 16'($urandom);
      FRAC      = 6'($urandom);
      MODE      = interp_mode_t'($urandom_range(0, 3));
      CH_IN     = 5'($urandom);
      #1;
      if (OUT_VALID && OUT_READY) begin
        if (q.size() == 0) begin
          chk("rand_extra", 32'(OUT_VALID), 0);
        end else begin
          e = q.pop_front();
          r = int'($signed(SAMPLE_OUT));
          chk("rand_data", 32'(SAMPLE_OUT), 32'(e.exp));
          chk("rand_ch", 32'(CH_OUT), 32'(e.ch));
          chk("rand_range",
              32'(r >= e.lo && r <= e.hi), 1);
          rcv++;
        end
      end
      if (IN_VALID && IN_READY) begin
        e.exp = ref_model(SAMPLE_1, SAMPLE_2, FRAC, MODE);
        e.ch  = CH_IN;
        e.lo  = int'($signed(SAMPLE_1));
        e.hi  = int'($signed(SAMPLE_2));
        if (e.lo > e.hi) begin
          r    = e.lo;
          e.lo = e.hi;
          e.hi = r;
        end
        q.push_back(e);
        sent++;
      end
      @(posedge Clk);
      @(negedge Clk);
    end
    chk("rand_drain", 32'(q.size()), 0);
    chk("rand_count", 32'(rcv), 10000);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lin_interp_pipe.md
# lin_interp_pipe

Parametrised, pipelined linear interpolator for the wavetable voice path. Accepts one (SAMPLE_1, SAMPLE_2, fraction, channel tag) tuple per cycle from the time-multiplexed voice sequencer and returns the interpolated sample three cycles later. It adds four selectable modes and a valid/ready handshake with full back-pressure. It sits between the wavetable read port and the per-voice envelope/mixer stage, replacing the fixed 16-bit / 6-bit combinational interpolator.

## Interface
- WIDTH, 16: sample width, signed two's complement.
- FRAC_BITS, 6: fraction width; fraction weight is FRAC / 2^FRAC_BITS.
- CH_BITS, 5: channel tag width (up to 32 voices).

Ports:
- Clk  in  1: single clock, all state on rising edge.
- Reset  in  1: asynchronous, active-high.
- IN_VALID  in  1: input tuple valid.
- IN_READY  out  1: block accepts tuple this cycle.
- SAMPLE_1  in  WIDTH: left sample (frac = 0 point).
- SAMPLE_2  in  WIDTH: right sample.
- FRAC  in  FRAC_BITS: interpolation position.
- MODE  in  2: interp_mode_t, captured per tuple.
- CH_IN  in  CH_BITS: channel tag, passed through unchanged.
- OUT_VALID  out  1: output valid.
- OUT_READY  in  1: downstream accepts.
- SAMPLE_OUT  out  WIDTH: interpolated sample.
- CH_OUT  out  CH_BITS: tag aligned with SAMPLE_OUT.

## Operation
- Modes: 00 LIN_TRUNC, result S1 + floor(D·FRAC / 2^FRAC_BITS); 01 LIN_ROUND, result S1 + floor((D·FRAC + 2^(FRAC_BITS−1)) / 2^FRAC_BITS); 10 NEAREST, result S2 if FRAC ≥ 2^(FRAC_BITS−1), else S1; 11 HOLD, result S1.
- D = S2 − S1 computed in WIDTH+1 bits (signed). Wrap of the difference is not permitted. Product is WIDTH+1+FRAC_BITS+1 bits, signed × unsigned. Shift is arithmetic (floor toward −∞).
- Result always lies in the closed range [min(S1,S2), max(S1,S2)]. No saturation logic is needed. The final sum is truncated to WIDTH bits.
- Stage 1: register S1, D, FRAC, MODE, tag.
- Stage 2: register product (or nearest/hold selection).
- Stage 3: add, round, and register the output.
- Each stage carries a valid bit.

## Timing
- Global advance enable EN = !OUT_VALID || OUT_READY. IN_READY = EN (combinational from OUT_VALID/OUT_READY only; no IN_VALID dependency).
- Transfer on IN_VALID && IN_READY. With no stall, the result appears on OUT_VALID exactly 3 cycles after acceptance.
- Throughput: 1 tuple/cycle.
- When EN = 0, all stages hold. SAMPLE_OUT, CH_OUT and OUT_VALID stay stable until OUT_READY.
- Bubbles (IN_VALID = 0 while EN = 1) propagate as valid = 0. They are not compressed.
- Reset: all stage valid bits, OUT_VALID, SAMPLE_OUT and CH_OUT clear to 0 immediately. In-flight tuples are discarded.
- IN_READY is 1 while Reset is asserted and after it is released.
- Tag order is preserved. No reordering occurs.
- FRAC = 0 yields S1 in every mode. FRAC = 2^FRAC_BITS−1 in NEAREST yields S2.

## Structure
- interp_pkg: typedef enum logic [1:0] interp_mode_t {LIN_TRUNC, LIN_ROUND, NEAREST, HOLD}; function computing the product width from WIDTH/FRAC_BITS.
- One sub-module, interp_stage: a generic valid+payload register with enable and asynchronous clear. It is instantiated three times.
- The arithmetic stays inline in lin_interp_pipe.

## Test plan
All cases use WIDTH=16, FRAC_BITS=6.
- LIN_TRUNC, S1=0x0000, S2=0x0100, FRAC=32, CH=3 → SAMPLE_OUT=0x0080, CH_OUT=3, OUT_VALID 3 cycles after acceptance.
- Full-scale swing, S1=0x7FFF, S2=0x8000, FRAC=32 → LIN_TRUNC gives 0xFFFF; LIN_ROUND gives 0x0000. This confirms the 17-bit difference has no wrap.
- NEAREST, S1=0x1000, S2=0x2000: FRAC=31 → 0x1000; FRAC=32 → 0x2000. HOLD with FRAC=63 → 0x1000.
- Stream 8 back-to-back tuples with OUT_READY low for cycles 4–6 → IN_READY low while the output is held. The output stays stable, all 8 results arrive in order, and none are lost or duplicated.
- Assert Reset with 3 tuples in flight → OUT_VALID=0 and SAMPLE_OUT=0 at once. No stale output after release. The first new tuple emerges 3 cycles after acceptance.
- Random S1/S2/FRAC/MODE for 10k tuples against a reference model → exact match, and the result always lies within [min, max] of S1 and S2.
